// File: rtl/regfile_cmd_master.sv
// regfile_cmd_master: command-driven initiator for a 32x32 two-read/one-write
// register file. It accepts WRITE/READ/FILL/CHECK commands on a valid/ready
// port, sequences the register file pins, and returns one response per command.
// Every output is a flop, so the pin values for a state are prepared on the
// edge that enters that state.
module regfile_cmd_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREGS   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_da,
  output logic [DATA_W-1:0] rsp_db,
  output logic [ADDR_W:0]   rsp_err_cnt,
  output logic [DATA_W-1:0] rf_Dc,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_Da,
  input  logic [DATA_W-1:0] rf_Db
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FILL,
    S_CHECK,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CHECK = 2'b11;

  // FILL ends on the last register; CHECK ends when rs2 reaches it
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [DATA_W-1:0]   first_q, first_d;
  logic                found_q, found_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_da_q, rsp_da_d;
  logic [DATA_W-1:0]   rsp_db_q, rsp_db_d;
  logic [ADDR_W:0]     rsp_err_cnt_q, rsp_err_cnt_d;
  logic [DATA_W-1:0]   rf_dc_q, rf_dc_d;
  logic                rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic [ADDR_W-1:0]   rf_rs1_q, rf_rs1_d;
  logic [ADDR_W-1:0]   rf_rs2_q, rf_rs2_d;

  logic [DATA_W-1:0]   exp_a, exp_b;
  logic                mis_a, mis_b;
  logic [ADDR_W:0]     err_sum;

  // Value a scrubbed register should hold: seed plus its index, except a
  // hard-wired zero register which always reads back as 0.
  function automatic logic [DATA_W-1:0] expected_val(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] seed
  );
    if ((R0_ZERO != 0) && (idx == '0)) begin
      return '0;
    end
    return seed + DATA_W'(idx);
  endfunction

  assign exp_a   = expected_val(rf_rs1_q, seed_q);
  assign exp_b   = expected_val(rf_rs2_q, seed_q);
  assign mis_a   = (rf_Da != exp_a);
  assign mis_b   = (rf_Db != exp_b);
  assign err_sum = err_q + (ADDR_W+1)'(mis_a) + (ADDR_W+1)'(mis_b);

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    err_d         = err_q;
    first_d       = first_q;
    found_d       = found_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_da_d      = rsp_da_q;
    rsp_db_d      = rsp_db_q;
    rsp_err_cnt_d = rsp_err_cnt_q;
    rf_dc_d       = '0;
    rf_write_d    = 1'b0;
    rf_rd_d       = '0;
    rf_rs1_d      = '0;
    rf_rs2_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          seed_d      = cmd_data;
          err_d       = '0;
          first_d     = '0;
          found_d     = 1'b0;
          case (cmd_op)
            OP_WRITE: begin
              state_d    = S_WRITE;
              rf_write_d = 1'b1;
              rf_rd_d    = cmd_addr_a;
              rf_dc_d    = cmd_data;
            end
            OP_READ: begin
              state_d  = S_READ;
              rf_rs1_d = cmd_addr_a;
              rf_rs2_d = cmd_addr_b;
            end
            OP_FILL: begin
              state_d    = S_FILL;
              rf_write_d = 1'b1;
              rf_rd_d    = '0;
              rf_dc_d    = cmd_data;
            end
            default: begin
              state_d  = S_CHECK;
              rf_rs1_d = '0;
              rf_rs2_d = ADDR_W'(1);
            end
          endcase
        end
      end

      S_WRITE: begin
        state_d       = S_RESP;
        rsp_valid_d   = 1'b1;
        rsp_da_d      = '0;
        rsp_db_d      = '0;
        rsp_err_cnt_d = '0;
      end

      S_READ: begin
        state_d       = S_RESP;
        rsp_valid_d   = 1'b1;
        rsp_da_d      = rf_Da;
        rsp_db_d      = rf_Db;
        rsp_err_cnt_d = '0;
      end

      S_FILL: begin
        if (rf_rd_q == LAST_IDX) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_da_d      = '0;
          rsp_db_d      = '0;
          rsp_err_cnt_d = '0;
        end else begin
          rf_write_d = 1'b1;
          rf_rd_d    = rf_rd_q + ADDR_W'(1);
          rf_dc_d    = rf_dc_q + DATA_W'(1);
        end
      end

      S_CHECK: begin
        err_d = err_sum;
        if (!found_q && mis_a) begin
          found_d = 1'b1;
          first_d = DATA_W'(rf_rs1_q);
        end else if (!found_q && mis_b) begin
          found_d = 1'b1;
          first_d = DATA_W'(rf_rs2_q);
        end
        if (rf_rs2_q == LAST_IDX) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_da_d      = found_d ? first_d : '1;
          rsp_db_d      = '0;
          rsp_err_cnt_d = err_sum;
        end else begin
          rf_rs1_d = rf_rs1_q + ADDR_W'(2);
          rf_rs2_d = rf_rs2_q + ADDR_W'(2);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d       = S_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_da_d      = '0;
          rsp_db_d      = '0;
          rsp_err_cnt_d = '0;
        end
      end

      default: begin
        state_d       = S_IDLE;
        cmd_ready_d   = 1'b1;
        rsp_valid_d   = 1'b0;
        rsp_da_d      = '0;
        rsp_db_d      = '0;
        rsp_err_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      seed_q        <= '0;
      err_q         <= '0;
      first_q       <= '0;
      found_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_da_q      <= '0;
      rsp_db_q      <= '0;
      rsp_err_cnt_q <= '0;
      rf_dc_q       <= '0;
      rf_write_q    <= 1'b0;
      rf_rd_q       <= '0;
      rf_rs1_q      <= '0;
      rf_rs2_q      <= '0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      err_q         <= err_d;
      first_q       <= first_d;
      found_q       <= found_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_da_q      <= rsp_da_d;
      rsp_db_q      <= rsp_db_d;
      rsp_err_cnt_q <= rsp_err_cnt_d;
      rf_dc_q       <= rf_dc_d;
      rf_write_q    <= rf_write_d;
      rf_rd_q       <= rf_rd_d;
      rf_rs1_q      <= rf_rs1_d;
      rf_rs2_q      <= rf_rs2_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_da      = rsp_da_q;
  assign rsp_db      = rsp_db_q;
  assign rsp_err_cnt = rsp_err_cnt_q;
  assign rf_Dc       = rf_dc_q;
  assign rf_write    = rf_write_q;
  assign rf_rd       = rf_rd_q;
  assign rf_rs1      = rf_rs1_q;
  assign rf_rs2      = rf_rs2_q;

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master: a 32x32 register file model hangs off the
// rf_* pins, and a separate command-level model of register contents predicts
// every response.
module tb_regfile_cmd_master;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CHECK = 2'b11;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_da;
  logic [DATA_W-1:0] rsp_db;
  logic [ADDR_W:0]   rsp_err_cnt;
  logic [DATA_W-1:0] rf_Dc;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_Da;
  logic [DATA_W-1:0] rf_Db;

  int compared;
  int mismatched;

  // register file model: captures on the edge, reads combinationally, reg 0 reads 0
  logic [DATA_W-1:0] rf_mem [NREGS];
  int                wr_cnt;
  logic [ADDR_W-1:0] last_wr_rd;
  logic [DATA_W-1:0] last_wr_dc;

  // command-level picture of what each register should hold
  logic [DATA_W-1:0] ref_mem [NREGS];

  int                got_lat;
  int                got_wr;
  logic [DATA_W-1:0] got_da;
  logic [DATA_W-1:0] got_db;
  logic [ADDR_W:0]   got_err;

  regfile_cmd_master #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS),
    .R0_ZERO(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_da     (rsp_da),
    .rsp_db     (rsp_db),
    .rsp_err_cnt(rsp_err_cnt),
    .rf_Dc      (rf_Dc),
    .rf_write   (rf_write),
    .rf_rd      (rf_rd),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_Da      (rf_Da),
    .rf_Db      (rf_Db)
  );

  // free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // register file storage and a count of write strobes seen at clock edges
  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_rd] <= rf_Dc;
      wr_cnt        <= wr_cnt + 1;
      last_wr_rd    <= rf_rd;
      last_wr_dc    <= rf_Dc;
    end
  end

  assign rf_Da = (rf_rs1 == '0) ? '0 : rf_mem[rf_rs1];
  assign rf_Db = (rf_rs2 == '0) ? '0 : rf_mem[rf_rs2];

  // hard stop in case a bounded wait is somehow bypassed
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] refRead(input int idx);
    return (idx == 0) ? '0 : ref_mem[idx];
  endfunction

  function automatic int refLatency(input logic [1:0] op);
    case (op)
      OP_FILL:  return NREGS + 1;
      OP_CHECK: return NREGS / 2 + 1;
      default:  return 2;
    endcase
  endfunction

  // expected CHECK result: scan index order, count misreads, note the first
  task automatic refCheck(input logic [DATA_W-1:0] seed, output int errs,
                          output logic [DATA_W-1:0] first);
    logic [DATA_W-1:0] want;
    errs  = 0;
    first = '1;
    for (int i = 0; i < NREGS; i++) begin
      want = (i == 0) ? '0 : seed + DATA_W'(i);
      if (refRead(i) != want) begin
        if (errs == 0) first = DATA_W'(i);
        errs++;
      end
    end
  endtask

  task automatic refFill(input logic [DATA_W-1:0] seed);
    for (int i = 0; i < NREGS; i++) ref_mem[i] = seed + DATA_W'(i);
  endtask

  // one complete command: offer, wait for the response, hold it for `hold`
  // cycles with rsp_ready low, then retire it and confirm the idle state
  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] b,
                               input logic [DATA_W-1:0] data, input int hold);
    int w0;
    int lat;
    w0         = wr_cnt;
    rsp_ready  = (hold == 0);
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid  = 1'b0;
    cmd_data   = $urandom;
    cmd_addr_a = ADDR_W'($urandom);
    checkOutput("cmd_ready_busy", cmd_ready, 0);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    got_lat = lat;
    got_wr  = wr_cnt - w0;
    got_da  = rsp_da;
    got_db  = rsp_db;
    got_err = rsp_err_cnt;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_da", rsp_da, got_da);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("post_valid", rsp_valid, 0);
    checkOutput("post_da", rsp_da, 0);
    checkOutput("post_err", rsp_err_cnt, 0);
    checkOutput("post_cmd_ready", cmd_ready, 1);
    checkOutput("post_rf_write", rf_write, 0);
    checkOutput("post_rf_rs1", {rf_rs1, rf_rs2}, 0);
  endtask

  initial begin
    int                errs;
    logic [DATA_W-1:0] first;
    logic [DATA_W-1:0] last_seed;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    int                r;
    int                hold;

    compared   = 0;
    mismatched = 0;
    wr_cnt     = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_data   = '0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
    repeat (3) tick();
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rf_write", rf_write, 0);
    checkOutput("rst_rf_pins", {rf_rd, rf_rs1, rf_rs2, rf_Dc}, 0);
    checkOutput("rst_rsp_data", {rsp_da, rsp_db, 26'(rsp_err_cnt)}, 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    // single write then dual read
    applyStimulus(OP_WRITE, 5'd1, 5'd0, 32'd88, 0);
    checkOutput("wr_strobes", got_wr, 1);
    checkOutput("wr_rd", last_wr_rd, 1);
    checkOutput("wr_dc", last_wr_dc, 88);
    checkOutput("wr_lat", got_lat, 2);
    checkOutput("wr_rsp", {got_da, got_db}, 0);
    ref_mem[1] = 32'd88;
    applyStimulus(OP_READ, 5'd1, 5'd0, 32'd0, 0);
    checkOutput("rd_lat", got_lat, 2);
    checkOutput("rd_da", got_da, 88);
    checkOutput("rd_db", got_db, 0);

    // fill then clean check
    applyStimulus(OP_FILL, 5'd0, 5'd0, 32'd100, 0);
    checkOutput("fill_strobes", got_wr, NREGS);
    checkOutput("fill_lat", got_lat, NREGS + 1);
    for (int i = 0; i < NREGS; i++)
      checkOutput($sformatf("fill_mem%0d", i), rf_mem[i], 100 + i);
    refFill(32'd100);
    applyStimulus(OP_CHECK, 5'd0, 5'd0, 32'd100, 0);
    checkOutput("chk_lat", got_lat, NREGS / 2 + 1);
    checkOutput("chk_strobes", got_wr, 0);
    checkOutput("chk_err", got_err, 0);
    checkOutput("chk_da", got_da, 32'hFFFF_FFFF);

    // fill that wraps past all-ones
    applyStimulus(OP_FILL, 5'd0, 5'd0, 32'hFFFF_FFFE, 0);
    refFill(32'hFFFF_FFFE);
    applyStimulus(OP_READ, 5'd1, 5'd2, 32'd0, 0);
    checkOutput("wrap_da", got_da, 32'hFFFF_FFFF);
    checkOutput("wrap_db", got_db, 0);

    // one corrupted register is located and counted
    applyStimulus(OP_FILL, 5'd0, 5'd0, 32'd0, 0);
    refFill(32'd0);
    applyStimulus(OP_WRITE, 5'd5, 5'd0, 32'd967, 0);
    ref_mem[5] = 32'd967;
    applyStimulus(OP_CHECK, 5'd0, 5'd0, 32'd0, 0);
    checkOutput("chk1_err", got_err, 1);
    checkOutput("chk1_da", got_da, 5);

    // response held off by the consumer
    applyStimulus(OP_WRITE, 5'd3, 5'd0, 32'd10, 0);
    ref_mem[3] = 32'd10;
    applyStimulus(OP_READ, 5'd3, 5'd3, 32'd0, 4);
    checkOutput("hold_rd_da", got_da, 10);
    checkOutput("hold_rd_db", got_db, 10);

    // reset in the middle of a fill
    rsp_ready  = 1'b1;
    cmd_op     = OP_FILL;
    cmd_data   = 32'd7;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    repeat (9) tick();
    checkOutput("abort_rd_before", rf_rd, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_rf_write", rf_write, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("abort_mem%0d", i), rf_mem[i], 7 + i);
    checkOutput("abort_mem10", rf_mem[10], ref_mem[10]);
    for (int i = 0; i < 10; i++) ref_mem[i] = 32'd7 + DATA_W'(i);
    repeat (3) begin
      tick();
      checkOutput("abort_no_rsp", rsp_valid, 0);
    end

    // random command mix against the command-level model
    last_seed = 32'd7;
    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 9);
      a    = ADDR_W'($urandom_range(0, NREGS - 1));
      b    = ADDR_W'($urandom_range(0, NREGS - 1));
      d    = $urandom;
      hold = $urandom_range(0, 2);
      if (r < 4) begin
        applyStimulus(OP_WRITE, a, b, d, hold);
        checkOutput("rnd_wr_strobes", got_wr, 1);
        checkOutput("rnd_wr_lat", got_lat, refLatency(OP_WRITE));
        ref_mem[a] = d;
      end else if (r < 8) begin
        applyStimulus(OP_READ, a, b, d, hold);
        checkOutput("rnd_rd_lat", got_lat, refLatency(OP_READ));
        checkOutput("rnd_rd_da", got_da, refRead(int'(a)));
        checkOutput("rnd_rd_db", got_db, refRead(int'(b)));
      end else if (r == 8) begin
        if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 + DATA_W'($urandom_range(0, 15));
        applyStimulus(OP_FILL, a, b, d, hold);
        checkOutput("rnd_fill_strobes", got_wr, NREGS);
        checkOutput("rnd_fill_lat", got_lat, refLatency(OP_FILL));
        refFill(d);
        last_seed = d;
      end else begin
        if ($urandom_range(0, 1) == 1) d = last_seed;
        applyStimulus(OP_CHECK, a, b, d, hold);
        refCheck(d, errs, first);
        checkOutput("rnd_chk_lat", got_lat, refLatency(OP_CHECK));
        checkOutput("rnd_chk_err", got_err, errs);
        checkOutput("rnd_chk_da", got_da, first);
        checkOutput("rnd_chk_db", got_db, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
